decode_queue: RTL and testbench
===============================

# decode_queue

Registered, parametrised successor to the combinational instruction decoder, sitting between fetch and execute in the pipelined RV32I hart. Each accepted instruction is decoded once on entry and stored, with its PC, in a DEPTH-entry FIFO of control bundles. Execute pops bundles through a valid/ready handshake. The block adds illegal-instruction detection, a halt latch on ECALL/EBREAK, flush, and optional M-extension decode.

## Interface
- PC_W, 32, width of the program counter carried with each entry
- DEPTH, 2, FIFO entries; power of two, ≥ 2
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_flush  in  1  discard all entries and clear halt
- i_if_valid  in  1  fetch offers an instruction
- o_if_ready  out  1  queue accepts this cycle
- i_if_inst  in  32  instruction word
- i_if_pc  in  PC_W  instruction address
- o_id_valid  out  1  head entry present
- i_id_ready  in  1  execute consumes head
- o_id_inst  out  32  head instruction word
- o_id_pc  out  PC_W  head PC
- o_id_ctrl  out  CTRL_W  head decoded control bundle (ctrl_t)
- o_id_illegal  out  1  head instruction is illegal
- o_id_halt  out  1  head instruction is ECALL/EBREAK
- o_count  out  $clog2(DEPTH+1)  occupancy
- o_halted  out  1  halt latch

## Operation
- Enqueue when i_if_valid && o_if_ready; dequeue when o_id_valid && i_id_ready. Both may occur in the same cycle; count unchanged.
- o_if_ready = (count < DEPTH) && !halted && !i_flush. It depends only on registered state and i_flush, never on i_id_ready. A full queue with a same-cycle dequeue still refuses.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is held separately.
- Decode covers R, OP-IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR and SYSTEM. Field encodings are the existing control encodings: opsel=funct3; arith=funct7[5] on shifts; sub=funct7[5] on R funct3 000; unsigned on SLTU/SLTIU and BLTU/BGEU; rd_dest_select 00 ALU, 01 imm, 10 PC+4, 11 load; one-hot format.
- Illegal conditions:
  - unknown opcode
  - R-type funct7 not 0x00, or not 0x20 on funct3 000/101
  - OP-IMM shift with funct7 other than 0x00/0x20 (0x20 only for funct3 101)
  - LOAD funct3 ∈ {3,6,7}
  - STORE funct3 > 2
  - BRANCH funct3 ∈ {2,3}
  - JALR funct3 ≠ 0
- An illegal entry is stored with ctrl all-zero (rd_wen=0, dmem_wen=0) and illegal=1.
- SYSTEM (opcode 1110011) is stored with ctrl all-zero and halt=1. Enqueueing it sets halted, which blocks further enqueues until i_flush or i_rst.
- i_flush zeroes pointers, count and halted. It overrides any same-cycle enqueue or dequeue.

## Timing
- Latency 1: an entry enqueued in cycle N shows o_id_valid=1 in N+1. There is no combinational fetch-to-execute bypass.
- Outputs come from registers and the storage array at the read pointer. Payload is don't-care while o_id_valid=0 but never X.
- Reset values:
  - o_id_valid=0, o_count=0, o_halted=0, o_if_ready=0 during reset (then 1 in the first cycle after reset)
  - storage zeroed, so o_id_inst, o_id_pc, o_id_ctrl, o_id_illegal and o_id_halt are 0
- Reset asserted mid-operation drops every entry in the next cycle, with the same result as reset from power-up.
- Execute must hold i_id_ready meaningful only while o_id_valid=1. Fetch must hold inputs stable while i_if_valid=1 && o_if_ready=0.

## Configuration
- RV32M_EN defined: R-type funct7=0x01 decodes legal with ctrl.mul=1 and opsel=funct3 (MUL..REMU).
- RV32M_EN undefined: the ctrl.mul bit does not exist and funct7=0x01 is illegal.

## Structure
- Package decode_pkg holds:
  - opcode localparams
  - rd_dest_select and format encodings
  - packed struct ctrl_t: jump, jalr, branch, branch_type, rd_dest_select, store_sel, load_sel, dmem_ren, dmem_wen, opsel, arith, unsigned, sub, auipc, alu_src, rd_wen, format, and mul under RV32M_EN
  - CTRL_W = $bits(ctrl_t)
- Sub-module decode_ctrl: purely combinational inst → {ctrl_t, illegal, halt}, instantiated once on the enqueue path. The FIFO and handshake logic live in decode_queue.

## Test plan
- Reset, then enqueue ADD x3,x1,x2 (0x002081B3) at PC 0x100 → next cycle o_id_valid=1, ctrl.opsel=0, ctrl.rd_wen=1, format=000001, o_count=1.
- DEPTH=2, i_id_ready=0, push 3 → o_if_ready=0 after 2 entries. Assert i_id_ready → entries pop in order, and ready returns the cycle after the first pop.
- Continuous push/pop for 10 instructions with both valid and ready held high → o_count stays at 1, the wrapped pointers deliver the PC sequence unchanged, and nothing is lost or duplicated.
- Enqueue 0x0000007F (unknown opcode) → o_id_illegal=1, ctrl==0.
- Enqueue 0x00100073 (EBREAK) → o_id_halt=1 and o_halted=1, then o_if_ready=0. i_flush → o_count=0, o_halted=0, ready=1.
- Enqueue 0x022081B3 (MUL) → ctrl.mul=1 with RV32M_EN defined, and o_id_illegal=1 without it.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode queue.
//   - RV32I opcode constants
//   - rd_dest_select and one-hot instruction-format encodings
//   - ctrl_t, the decoded control bundle carried through the queue
//   - CTRL_W, the width of ctrl_t
// Build option: RV32M_EN adds the ctrl_t.mul bit for M-extension ops.
package decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Source of the rd write-back value
    localparam logic [1:0] RD_ALU  = 2'b00;
    localparam logic [1:0] RD_IMM  = 2'b01;
    localparam logic [1:0] RD_PC4  = 2'b10;
    localparam logic [1:0] RD_LOAD = 2'b11;

    // One-hot instruction format
    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

    typedef struct packed {
        logic       jump;
        logic       jalr;
        logic       branch;
        logic [2:0] branch_type;
        logic [1:0] rd_dest_select;
        logic [1:0] store_sel;
        logic [2:0] load_sel;
        logic       dmem_ren;
        logic       dmem_wen;
        logic [2:0] opsel;
        logic       arith;
        logic       unsigned_op;
        logic       sub;
        logic       auipc;
        logic       alu_src;
        logic       rd_wen;
        logic [5:0] format;
`ifdef RV32M_EN
        logic       mul;
`endif
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and execute-side handshake bundle of the
// decode queue.
//   fetch   : i_if_valid / o_if_ready / i_if_inst / i_if_pc
//   execute : o_id_valid / i_id_ready / o_id_inst / o_id_pc / o_id_ctrl /
//             o_id_illegal / o_id_halt
//   control : i_flush in, o_count / o_halted status out
// Modports: slave = the queue itself, master = fetch/execute/control side.
interface decode_queue_if #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
);
    import decode_pkg::*;

    logic                         i_flush;
    logic                         i_if_valid;
    logic                         o_if_ready;
    logic [31:0]                  i_if_inst;
    logic [PC_W-1:0]              i_if_pc;
    logic                         o_id_valid;
    logic                         i_id_ready;
    logic [31:0]                  o_id_inst;
    logic [PC_W-1:0]              o_id_pc;
    ctrl_t                        o_id_ctrl;
    logic                         o_id_illegal;
    logic                         o_id_halt;
    logic [$clog2(DEPTH+1)-1:0]   o_count;
    logic                         o_halted;

    modport slave (
        input  i_flush, i_if_valid, i_if_inst, i_if_pc, i_id_ready,
        output o_if_ready, o_id_valid, o_id_inst, o_id_pc, o_id_ctrl,
               o_id_illegal, o_id_halt, o_count, o_halted
    );

    modport master (
        output i_flush, i_if_valid, i_if_inst, i_if_pc, i_id_ready,
        input  o_if_ready, o_id_valid, o_id_inst, o_id_pc, o_id_ctrl,
               o_id_illegal, o_id_halt, o_count, o_halted
    );

endinterface

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational RV32I instruction decoder.
//   inst    in  32      instruction word
//   ctrl    out ctrl_t  decoded control bundle (all-zero if illegal/SYSTEM)
//   illegal out 1       encoding not recognised
//   halt    out 1       SYSTEM opcode (ECALL/EBREAK)
// Build option: RV32M_EN makes R-type funct7=0x01 legal with ctrl.mul=1.
module decode_ctrl
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic        halt
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    ctrl_t      dec;
    logic       bad;
    logic       sys;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    // Register and immediate fields are extracted downstream, not here.
    logic unused_fields;
    assign unused_fields = ^{inst[24:15], inst[11:7]};

    always_comb begin
        dec = '0;
        bad = 1'b0;
        sys = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.format         = FMT_R;
                dec.rd_wen         = 1'b1;
                dec.rd_dest_select = RD_ALU;
                dec.opsel          = funct3;
                if (funct7 == 7'h00) begin
                    dec.unsigned_op = (funct3 == 3'b011);
                end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec.sub   = (funct3 == 3'b000);
                    dec.arith = (funct3 == 3'b101);
                end
`ifdef RV32M_EN
                else if (funct7 == 7'h01) begin
                    dec.mul = 1'b1;
                end
`endif
                else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.format      = FMT_I;
                dec.rd_wen      = 1'b1;
                dec.alu_src     = 1'b1;
                dec.opsel       = funct3;
                dec.unsigned_op = (funct3 == 3'b011);
                // Only the shift forms constrain funct7 (it is imm[11:5] otherwise)
                if (funct3 == 3'b001) begin
                    bad = (funct7 != 7'h00);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20) begin
                        dec.arith = 1'b1;
                    end else if (funct7 != 7'h00) begin
                        bad = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec.format         = FMT_U;
                dec.rd_wen         = 1'b1;
                dec.alu_src        = 1'b1;
                dec.rd_dest_select = RD_IMM;
            end
            OPC_AUIPC: begin
                dec.format         = FMT_U;
                dec.rd_wen         = 1'b1;
                dec.alu_src        = 1'b1;
                dec.auipc          = 1'b1;
                dec.rd_dest_select = RD_ALU;
            end
            OPC_LOAD: begin
                dec.format         = FMT_I;
                dec.rd_wen         = 1'b1;
                dec.alu_src        = 1'b1;
                dec.dmem_ren       = 1'b1;
                dec.load_sel       = funct3;
                dec.rd_dest_select = RD_LOAD;
                bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                dec.format    = FMT_S;
                dec.alu_src   = 1'b1;
                dec.dmem_wen  = 1'b1;
                dec.store_sel = funct3[1:0];
                bad = (funct3 > 3'd2);
            end
            OPC_BRANCH: begin
                dec.format      = FMT_B;
                dec.branch      = 1'b1;
                dec.branch_type = funct3;
                dec.unsigned_op = funct3[2] & funct3[1];
                bad = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OPC_JAL: begin
                dec.format         = FMT_J;
                dec.jump           = 1'b1;
                dec.rd_wen         = 1'b1;
                dec.rd_dest_select = RD_PC4;
            end
            OPC_JALR: begin
                dec.format         = FMT_I;
                dec.jalr           = 1'b1;
                dec.rd_wen         = 1'b1;
                dec.alu_src        = 1'b1;
                dec.rd_dest_select = RD_PC4;
                bad = (funct3 != 3'd0);
            end
            OPC_SYSTEM: begin
                sys = 1'b1;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    // Illegal entries must never write rd or memory, so the bundle is cleared.
    assign ctrl    = bad ? '0 : dec;
    assign illegal = bad;
    assign halt    = sys;

endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes each accepted instruction once and holds the
// resulting control bundles, with PC and raw word, in a DEPTH-entry FIFO.
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset (clears state and storage)
//   bus    decode_queue_if.slave: fetch handshake in, execute handshake
//          out, flush in, occupancy and halt status out
// Parameters: PC_W (PC width), DEPTH (entries, power of two, >= 2).
// Build option: RV32M_EN (see decode_ctrl) enables M-extension decode.
module decode_queue
    import decode_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    decode_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        ctrl_t           ctrl;
        logic            illegal;
        logic            halt;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               halted;

    ctrl_t              dec_ctrl;
    logic               dec_illegal;
    logic               dec_halt;
    logic               ready;
    logic               push;
    logic               pop;

    decode_ctrl u_decode_ctrl (
        .inst    (bus.i_if_inst),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .halt    (dec_halt)
    );

    // Readiness ignores i_id_ready: a full queue refuses even if it pops now.
    assign ready = !i_rst && (count < CNT_W'(DEPTH)) && !halted && !bus.i_flush;
    assign push  = bus.i_if_valid && ready;
    assign pop   = (count != '0) && bus.i_id_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
            if (push && dec_halt) begin
                halted <= 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the head payload is never X.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{inst:    bus.i_if_inst,
                             pc:      bus.i_if_pc,
                             ctrl:    dec_ctrl,
                             illegal: dec_illegal,
                             halt:    dec_halt};
        end
    end

    assign bus.o_if_ready   = ready;
    assign bus.o_id_valid   = (count != '0);
    assign bus.o_id_inst    = mem[rd_ptr].inst;
    assign bus.o_id_pc      = mem[rd_ptr].pc;
    assign bus.o_id_ctrl    = mem[rd_ptr].ctrl;
    assign bus.o_id_illegal = mem[rd_ptr].illegal;
    assign bus.o_id_halt    = mem[rd_ptr].halt;
    assign bus.o_count      = count;
    assign bus.o_halted     = halted;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: self-checking bench for decode_queue.
// A queue-based reference model tracks occupancy, halt and head contents;
// the expected control bundle is computed from the RV32I encoding rules.
// Directed sequences are followed by randomized traffic with flushes and
// occasional resets. Honors RV32M_EN when defined at compile time.
module tb_decode_queue;
    import decode_pkg::*;

    localparam int PC_W  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        ctrl_t ctrl;
        logic  illegal;
        logic  halt;
    } dec_t;

    typedef struct {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    ent_t q[$];
    bit   m_halted = 1'b0;
    bit   m_ready  = 1'b0;

    decode_queue_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    decode_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected decode derived from the encoding rules: legality first,
    // then the fields of the instruction class.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t       r;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         ok;
        bit         m_on;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        r  = '0;
`ifdef RV32M_EN
        m_on = 1'b1;
`else
        m_on = 1'b0;
`endif
        case (op)
            OPC_OP:     ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
                             || (m_on && f7 == 7'h01);
            OPC_OP_IMM: ok = !(f3 == 3'd1 && f7 != 7'h00)
                             && !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            OPC_LOAD:   ok = !(f3 inside {3'd3, 3'd6, 3'd7});
            OPC_STORE:  ok = (f3 <= 3'd2);
            OPC_BRANCH: ok = !(f3 inside {3'd2, 3'd3});
            OPC_JALR:   ok = (f3 == 3'd0);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM: ok = 1'b1;
            default:    ok = 1'b0;
        endcase
        if (!ok) begin
            r.illegal = 1'b1;
            return r;
        end
        if (op == OPC_SYSTEM) begin
            r.halt = 1'b1;
            return r;
        end
        case (op)
            OPC_OP: begin
                r.ctrl.format = FMT_R;
                r.ctrl.rd_wen = 1'b1;
                r.ctrl.opsel  = f3;
                if (f7 == 7'h01) begin
`ifdef RV32M_EN
                    r.ctrl.mul = 1'b1;
`endif
                end else begin
                    r.ctrl.sub         = (f3 == 3'd0) && f7[5];
                    r.ctrl.arith       = (f3 == 3'd5) && f7[5];
                    r.ctrl.unsigned_op = (f3 == 3'd3);
                end
            end
            OPC_OP_IMM: begin
                r.ctrl.format      = FMT_I;
                r.ctrl.rd_wen      = 1'b1;
                r.ctrl.alu_src     = 1'b1;
                r.ctrl.opsel       = f3;
                r.ctrl.arith       = (f3 == 3'd5) && f7[5];
                r.ctrl.unsigned_op = (f3 == 3'd3);
            end
            OPC_LUI: begin
                r.ctrl.format = FMT_U;
                r.ctrl.rd_wen = 1'b1;
                r.ctrl.alu_src = 1'b1;
                r.ctrl.rd_dest_select = RD_IMM;
            end
            OPC_AUIPC: begin
                r.ctrl.format = FMT_U;
                r.ctrl.rd_wen = 1'b1;
                r.ctrl.alu_src = 1'b1;
                r.ctrl.auipc = 1'b1;
            end
            OPC_LOAD: begin
                r.ctrl.format = FMT_I;
                r.ctrl.rd_wen = 1'b1;
                r.ctrl.alu_src = 1'b1;
                r.ctrl.dmem_ren = 1'b1;
                r.ctrl.load_sel = f3;
                r.ctrl.rd_dest_select = RD_LOAD;
            end
            OPC_STORE: begin
                r.ctrl.format = FMT_S;
                r.ctrl.alu_src = 1'b1;
                r.ctrl.dmem_wen = 1'b1;
                r.ctrl.store_sel = f3[1:0];
            end
            OPC_BRANCH: begin
                r.ctrl.format = FMT_B;
                r.ctrl.branch = 1'b1;
                r.ctrl.branch_type = f3;
                r.ctrl.unsigned_op = (f3 >= 3'd6);
            end
            OPC_JAL: begin
                r.ctrl.format = FMT_J;
                r.ctrl.jump = 1'b1;
                r.ctrl.rd_wen = 1'b1;
                r.ctrl.rd_dest_select = RD_PC4;
            end
            default: begin // JALR
                r.ctrl.format = FMT_I;
                r.ctrl.jalr = 1'b1;
                r.ctrl.rd_wen = 1'b1;
                r.ctrl.alu_src = 1'b1;
                r.ctrl.rd_dest_select = RD_PC4;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: w[6:0] = OPC_OP;
            1: w[6:0] = OPC_OP_IMM;
            2: w[6:0] = OPC_LUI;
            3: w[6:0] = OPC_AUIPC;
            4: w[6:0] = OPC_LOAD;
            5: w[6:0] = OPC_STORE;
            6: w[6:0] = OPC_BRANCH;
            7: w[6:0] = OPC_JAL;
            8: w[6:0] = OPC_JALR;
            9: w[6:0] = OPC_SYSTEM;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    // Compare every observable output with the model's current state.
    task automatic check_state();
        dec_t d;
        m_ready = !rst && (q.size() < DEPTH) && !m_halted && !bus.i_flush;
        check("ready",  64'(bus.o_if_ready), 64'(m_ready));
        check("valid",  64'(bus.o_id_valid), 64'(q.size() != 0));
        check("count",  64'(bus.o_count),    64'(q.size()));
        check("halted", 64'(bus.o_halted),   64'(m_halted));
        if (q.size() != 0) begin
            d = ref_decode(q[0].inst);
            check("head_inst",    64'(bus.o_id_inst),    64'(q[0].inst));
            check("head_pc",      64'(bus.o_id_pc),      64'(q[0].pc));
            check("head_ctrl",    64'(bus.o_id_ctrl),    64'(d.ctrl));
            check("head_illegal", 64'(bus.o_id_illegal), 64'(d.illegal));
            check("head_halt",    64'(bus.o_id_halt),    64'(d.halt));
        end
    endtask

    // Inputs are set at the falling edge before calling; checks, then
    // advances one clock and updates the model from the applied inputs.
    task automatic step();
        ent_t e;
        #1;
        check_state();
        @(posedge clk);
        if (rst || bus.i_flush) begin
            q.delete();
            m_halted = 1'b0;
        end else begin
            if (q.size() != 0 && bus.i_id_ready) begin
                void'(q.pop_front());
            end
            if (bus.i_if_valid && m_ready) begin
                e.inst = bus.i_if_inst;
                e.pc   = bus.i_if_pc;
                q.push_back(e);
                if (bus.i_if_inst[6:0] == OPC_SYSTEM) begin
                    m_halted = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [PC_W-1:0] pc);
        bus.i_if_valid = 1'b1;
        bus.i_if_inst  = inst;
        bus.i_if_pc    = pc;
        step();
        bus.i_if_valid = 1'b0;
    endtask

    task automatic drain();
        bus.i_if_valid = 1'b0;
        bus.i_id_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            step();
        end
        bus.i_id_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_flush    = 1'b0;
        bus.i_if_valid = 1'b0;
        bus.i_if_inst  = '0;
        bus.i_if_pc    = '0;
        bus.i_id_ready = 1'b0;
        rst            = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset state, including zeroed storage behind the head
        step();
        check("rst_inst",    64'(bus.o_id_inst),    64'(0));
        check("rst_pc",      64'(bus.o_id_pc),      64'(0));
        check("rst_ctrl",    64'(bus.o_id_ctrl),    64'(0));
        check("rst_illegal", 64'(bus.o_id_illegal), 64'(0));
        check("rst_halt",    64'(bus.o_id_halt),    64'(0));
        check("rst_ready",   64'(bus.o_if_ready),   64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.o_if_ready), 64'(1));

        // ADD x3,x1,x2 at 0x100
        push_one(32'h002081B3, 32'h100);
        check("add_valid",  64'(bus.o_id_valid),       64'(1));
        check("add_opsel",  64'(bus.o_id_ctrl.opsel),  64'(0));
        check("add_rd_wen", 64'(bus.o_id_ctrl.rd_wen), 64'(1));
        check("add_format", 64'(bus.o_id_ctrl.format), 64'(6'b000001));
        check("add_count",  64'(bus.o_count),          64'(1));
        drain();

        // Fill to DEPTH, third push refused; ready returns after first pop
        bus.i_if_valid = 1'b1;
        bus.i_if_inst  = 32'h00108093;
        for (int k = 0; k < 3; k++) begin
            bus.i_if_pc = 32'h300 + 32'(4 * k);
            step();
        end
        check("full_ready", 64'(bus.o_if_ready), 64'(0));
        check("full_count", 64'(bus.o_count),    64'(2));
        bus.i_id_ready = 1'b1;
        step();
        check("pop_ready", 64'(bus.o_if_ready), 64'(1));
        drain();

        // Continuous streaming: one entry in flight, PCs delivered in order
        bus.i_if_valid = 1'b1;
        bus.i_id_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.i_if_inst = 32'h00108093 + 32'(k << 20);
            bus.i_if_pc   = 32'h400 + 32'(4 * k);
            step();
            check("stream_count", 64'(bus.o_count), 64'(1));
            check("stream_pc",    64'(bus.o_id_pc), 64'(32'h400 + 32'(4 * k)));
        end
        drain();

        // Unknown opcode
        push_one(32'h0000007F, 32'h500);
        check("unk_illegal", 64'(bus.o_id_illegal), 64'(1));
        check("unk_ctrl",    64'(bus.o_id_ctrl),    64'(0));
        drain();

        // EBREAK halts, flush releases
        push_one(32'h00100073, 32'h600);
        check("ebreak_halt",   64'(bus.o_id_halt),  64'(1));
        check("ebreak_halted", 64'(bus.o_halted),   64'(1));
        check("ebreak_ready",  64'(bus.o_if_ready), 64'(0));
        check("ebreak_ctrl",   64'(bus.o_id_ctrl),  64'(0));
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        #1;
        check("flush_count",  64'(bus.o_count),    64'(0));
        check("flush_halted", 64'(bus.o_halted),   64'(0));
        check("flush_ready",  64'(bus.o_if_ready), 64'(1));

        // MUL x3,x1,x2
        push_one(32'h022081B3, 32'h700);
`ifdef RV32M_EN
        check("mul_bit",     64'(bus.o_id_ctrl.mul), 64'(1));
        check("mul_illegal", 64'(bus.o_id_illegal),  64'(0));
`else
        check("mul_illegal", 64'(bus.o_id_illegal),  64'(1));
        check("mul_ctrl",    64'(bus.o_id_ctrl),     64'(0));
`endif
        drain();

        // Randomized traffic with flushes and occasional mid-run reset
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            bus.i_flush    = ($urandom_range(0, 15) == 0);
            bus.i_if_valid = ($urandom_range(0, 3) != 0);
            bus.i_id_ready = ($urandom_range(0, 2) != 0);
            bus.i_if_inst  = rand_inst();
            bus.i_if_pc    = $urandom;
            step();
        end
        rst = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_if_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
